// File: rtl/calc_pkg.sv
// calc_pkg
//   Shared types and constants for the calculator datapath. Imported by the
//   ALU sequencing controller (calc_ctrl) and by the ALU itself so both sides
//   agree on op-code encoding.
//
//   fct_e        : ALU op code (add, sub, mul, div)
//   ctrl_state_e : controller FSM states
//   OP_CNT_W     : width of the completed-operation counter
package calc_pkg;

    typedef enum logic [1:0] {
        ADD = 2'b00,
        SUB = 2'b01,
        MUL = 2'b10,
        DIV = 2'b11
    } fct_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } ctrl_state_e;

    localparam int OP_CNT_W = 8;

endpackage

// File: rtl/calc_ctrl.sv
// calc_ctrl
//   Sequencing controller for the calculator's combinational ALU. Accepts one
//   request through a valid/ready handshake and latches the operands. It then
//   holds them on the ALU inputs for at least EXEC_CYCLES cycles. It captures
//   the ALU result and remainder and presents them through a second
//   valid/ready handshake. The ALU sits beside this block, not inside it.
//
//   Parameters:
//     WIDTH       : operand width; result/remainder are 2*WIDTH
//     EXEC_CYCLES : minimum cycles operands are held before capture (1..16)
//
//   Ports:
//     clk_i, rst_i                 : clock (rising edge), async active-high reset
//     req_valid_i / req_ready_o    : request handshake
//     a_i, b_i, fct_i              : request operands and op code
//     alu_a_o, alu_b_o, alu_fct_o  : latched operands driven to the ALU
//     alu_res_i, alu_rem_i         : ALU result / remainder
//     alu_done_i                   : ALU result is usable
//     res_valid_o / res_ready_i    : result handshake
//     res_o, rem_o                 : registered result / remainder
//     err_o                        : divide-by-zero flag for the presented result
//     busy_o                       : high while in EXEC or RESP
//     op_count_o                   : completed-operation counter (wraps)
//
//   Build option:
//     CALC_DIVZERO_ERR_EN : when defined, err_o flags a divide by zero at the
//                           capture edge; otherwise err_o is tied low.
module calc_ctrl
    import calc_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int EXEC_CYCLES = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [WIDTH-1:0]      a_i,
    input  logic [WIDTH-1:0]      b_i,
    input  logic [1:0]            fct_i,
    output logic [WIDTH-1:0]      alu_a_o,
    output logic [WIDTH-1:0]      alu_b_o,
    output logic [1:0]            alu_fct_o,
    input  logic [2*WIDTH-1:0]    alu_res_i,
    input  logic [2*WIDTH-1:0]    alu_rem_i,
    input  logic                  alu_done_i,
    output logic                  res_valid_o,
    input  logic                  res_ready_i,
    output logic [2*WIDTH-1:0]    res_o,
    output logic [2*WIDTH-1:0]    rem_o,
    output logic                  err_o,
    output logic                  busy_o,
    output logic [OP_CNT_W-1:0]   op_count_o
);

    // Four bits cover the largest load value (EXEC_CYCLES-1 = 15).
    localparam int               CNT_W    = 4;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(EXEC_CYCLES - 1);

    ctrl_state_e           state_q,   state_d;
    logic [CNT_W-1:0]      cnt_q,     cnt_d;
    logic [WIDTH-1:0]      opA_q,     opA_d;
    logic [WIDTH-1:0]      opB_q,     opB_d;
    fct_e                  opFct_q,   opFct_d;
    logic [2*WIDTH-1:0]    res_q,     res_d;
    logic [2*WIDTH-1:0]    rem_q,     rem_d;
    logic [OP_CNT_W-1:0]   opCount_q, opCount_d;

    logic accept;
    logic capture;

`ifdef CALC_DIVZERO_ERR_EN
    logic err_q, err_d;
`endif

    // A request is taken only in IDLE. The result is captured once the hold
    // window has expired and the ALU reports done.
    assign accept  = (state_q == IDLE) && req_valid_i;
    assign capture = (state_q == EXEC) && (cnt_q == '0) && alu_done_i;

    // Next-state and datapath update. Every register holds by default, so
    // the ALU operand registers keep their last values outside EXEC.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        opA_d     = opA_q;
        opB_d     = opB_q;
        opFct_d   = opFct_q;
        res_d     = res_q;
        rem_d     = rem_q;
        opCount_d = opCount_q;
`ifdef CALC_DIVZERO_ERR_EN
        err_d     = err_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    opA_d   = a_i;
                    opB_d   = b_i;
                    opFct_d = fct_e'(fct_i);
                    cnt_d   = CNT_LOAD;
                    state_d = EXEC;
`ifdef CALC_DIVZERO_ERR_EN
                    err_d   = 1'b0;
`endif
                end
            end
            EXEC: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (capture) begin
                    res_d     = alu_res_i;
                    rem_d     = alu_rem_i;
                    opCount_d = opCount_q + OP_CNT_W'(1);
                    state_d   = RESP;
`ifdef CALC_DIVZERO_ERR_EN
                    err_d     = (opFct_q == DIV) && (opB_q == '0);
`endif
                end
            end
            RESP: begin
                if (res_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with asynchronous reset. A reset in the
    // middle of an operation discards it before the counter is bumped.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            opA_q     <= '0;
            opB_q     <= '0;
            opFct_q   <= ADD;
            res_q     <= '0;
            rem_q     <= '0;
            opCount_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            opA_q     <= opA_d;
            opB_q     <= opB_d;
            opFct_q   <= opFct_d;
            res_q     <= res_d;
            rem_q     <= rem_d;
            opCount_q <= opCount_d;
        end
    end

`ifdef CALC_DIVZERO_ERR_EN
    // Divide-by-zero flag register, present only when the check is built in.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    assign req_ready_o = (state_q == IDLE);
    assign res_valid_o = (state_q == RESP);
    assign busy_o      = (state_q != IDLE);
    assign alu_a_o     = opA_q;
    assign alu_b_o     = opB_q;
    assign alu_fct_o   = opFct_q;
    assign res_o       = res_q;
    assign rem_o       = rem_q;
    assign op_count_o  = opCount_q;

endmodule

// File: tb/tb_calc_ctrl.sv
// tb_calc_ctrl
//   Self-checking bench for calc_ctrl (WIDTH=8, EXEC_CYCLES=2) with a
//   behavioural ALU beside it. Expected results are pushed to a scoreboard
//   queue when a request is driven, and popped when res_valid_o appears.
//   The expected divide-by-zero flag follows CALC_DIVZERO_ERR_EN.
module tb_calc_ctrl;
    import calc_pkg::*;

    localparam int WIDTH       = 8;
    localparam int EXEC_CYCLES = 2;

`ifdef CALC_DIVZERO_ERR_EN
    localparam logic ERR_ON = 1'b1;
`else
    localparam logic ERR_ON = 1'b0;
`endif

    typedef struct {
        logic [2*WIDTH-1:0] res;
        logic [2*WIDTH-1:0] rem;
        logic               err;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 reqValid;
    logic                 reqReady;
    logic [WIDTH-1:0]     aIn;
    logic [WIDTH-1:0]     bIn;
    logic [1:0]           fctIn;
    logic [WIDTH-1:0]     aluA;
    logic [WIDTH-1:0]     aluB;
    logic [1:0]           aluFct;
    logic [2*WIDTH-1:0]   aluRes;
    logic [2*WIDTH-1:0]   aluRem;
    logic                 aluDone;
    logic                 resValid;
    logic                 resReady;
    logic [2*WIDTH-1:0]   resOut;
    logic [2*WIDTH-1:0]   remOut;
    logic                 errOut;
    logic                 busy;
    logic [OP_CNT_W-1:0]  opCount;

    exp_t sbQ[$];
    int   nTests   = 0;
    int   nFail    = 0;
    int   expCount = 0;

    // Operation table: add, sub underflow, mul, div, div by zero.
    logic [WIDTH-1:0]   tblA  [5] = '{8'd25, 8'd3, 8'd200, 8'd100, 8'd9};
    logic [WIDTH-1:0]   tblB  [5] = '{8'd17, 8'd5, 8'd200, 8'd7,   8'd0};
    logic [1:0]         tblF  [5] = '{2'b00, 2'b01, 2'b10, 2'b11,  2'b11};
    logic [2*WIDTH-1:0] tblRes[5] = '{16'd42, 16'hFFFE, 16'h9C40, 16'd14, 16'd0};
    logic [2*WIDTH-1:0] tblRem[5] = '{16'd0,  16'd0,    16'd0,    16'd2,  16'd0};

    always #5 clk = ~clk;

    // Behavioural combinational ALU; divide by zero returns 0/0.
    always_comb begin
        aluRes = '0;
        aluRem = '0;
        case (aluFct)
            2'b00: aluRes = 16'(aluA) + 16'(aluB);
            2'b01: aluRes = 16'(aluA) - 16'(aluB);
            2'b10: aluRes = 16'(aluA) * 16'(aluB);
            default: begin
                if (aluB != '0) begin
                    aluRes = 16'(aluA / aluB);
                    aluRem = 16'(aluA % aluB);
                end
            end
        endcase
    end

    calc_ctrl #(
        .WIDTH       (WIDTH),
        .EXEC_CYCLES (EXEC_CYCLES)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (reqValid),
        .req_ready_o (reqReady),
        .a_i         (aIn),
        .b_i         (bIn),
        .fct_i       (fctIn),
        .alu_a_o     (aluA),
        .alu_b_o     (aluB),
        .alu_fct_o   (aluFct),
        .alu_res_i   (aluRes),
        .alu_rem_i   (aluRem),
        .alu_done_i  (aluDone),
        .res_valid_o (resValid),
        .res_ready_i (resReady),
        .res_o       (resOut),
        .rem_o       (remOut),
        .err_o       (errOut),
        .busy_o      (busy),
        .op_count_o  (opCount)
    );

    // Drive one request; returns #1 after the accept edge with valid dropped.
    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic [1:0] f);
        reqValid = 1'b1;
        aIn      = a;
        bIn      = b;
        fctIn    = f;
        @(posedge clk);
        #1;
        reqValid = 1'b0;
    endtask

    // Count edges until res_valid_o rises, bounded.
    task automatic collectResult(output int edges);
        edges = 0;
        while (resValid !== 1'b1 && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst      = 1'b0;
        reqValid = 1'b0;
        aIn      = '0;
        bIn      = '0;
        fctIn    = '0;
        aluDone  = 1'b1;
        resReady = 1'b1;
        #2 rst = 1'b1;
        #1;
        nTests++; if (reqReady !== 1'b1) begin nFail++; $display("[TB] FAIL reset_req_ready: got %b, expected 1", reqReady); end
        nTests++; if (resValid !== 1'b0) begin nFail++; $display("[TB] FAIL reset_res_valid: got %b, expected 0", resValid); end
        nTests++; if (busy !== 1'b0) begin nFail++; $display("[TB] FAIL reset_busy: got %b, expected 0", busy); end
        nTests++; if (resOut !== 16'd0 || remOut !== 16'd0) begin nFail++; $display("[TB] FAIL reset_res_rem: got %h/%h, expected 0000/0000", resOut, remOut); end
        nTests++; if (errOut !== 1'b0) begin nFail++; $display("[TB] FAIL reset_err: got %b, expected 0", errOut); end
        nTests++; if (opCount !== 8'd0) begin nFail++; $display("[TB] FAIL reset_op_count: got %0d, expected 0", opCount); end
        nTests++; if (aluA !== 8'd0 || aluB !== 8'd0) begin nFail++; $display("[TB] FAIL reset_alu_ops: got %h/%h, expected 00/00", aluA, aluB); end
        stepCycle();
        stepCycle();
        rst = 1'b0;
        stepCycle();
        expCount = 0;
    endtask

    task automatic test_arith();
        int   edges;
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            sbQ.push_back('{tblRes[i], tblRem[i], (i == 4) ? ERR_ON : 1'b0});
            applyStimulus(tblA[i], tblB[i], tblF[i]);
            nTests++; if (busy !== 1'b1 || reqReady !== 1'b0) begin nFail++; $display("[TB] FAIL arith%0d_exec_flags: got busy=%b ready=%b, expected busy=1 ready=0", i, busy, reqReady); end
            collectResult(edges);
            nTests++; if (resValid !== 1'b1 || edges != EXEC_CYCLES) begin nFail++; $display("[TB] FAIL arith%0d_latency: got %0d edges valid=%b, expected %0d edges", i, edges, resValid, EXEC_CYCLES); end
            e = sbQ.pop_front();
            expCount = (expCount + 1) % 256;
            nTests++; if (resOut !== e.res) begin nFail++; $display("[TB] FAIL arith%0d_res: got %h, expected %h", i, resOut, e.res); end
            nTests++; if (remOut !== e.rem) begin nFail++; $display("[TB] FAIL arith%0d_rem: got %h, expected %h", i, remOut, e.rem); end
            nTests++; if (errOut !== e.err) begin nFail++; $display("[TB] FAIL arith%0d_err: got %b, expected %b", i, errOut, e.err); end
            nTests++; if (opCount !== 8'(expCount)) begin nFail++; $display("[TB] FAIL arith%0d_op_count: got %0d, expected %0d", i, opCount, expCount); end
            stepCycle();
            nTests++; if (resValid !== 1'b0 || reqReady !== 1'b1) begin nFail++; $display("[TB] FAIL arith%0d_handoff: got valid=%b ready=%b, expected valid=0 ready=1", i, resValid, reqReady); end
        end
    endtask

    task automatic test_err_clear();
        int   edges;
        exp_t e;
        // The divide-by-zero flag from the previous operation persists in IDLE.
        nTests++; if (errOut !== ERR_ON) begin nFail++; $display("[TB] FAIL err_hold_idle: got %b, expected %b", errOut, ERR_ON); end
        sbQ.push_back('{16'd2, 16'd0, 1'b0});
        applyStimulus(8'd1, 8'd1, 2'b00);
        nTests++; if (errOut !== 1'b0) begin nFail++; $display("[TB] FAIL err_clear_on_accept: got %b, expected 0", errOut); end
        collectResult(edges);
        e = sbQ.pop_front();
        expCount = (expCount + 1) % 256;
        nTests++; if (resValid !== 1'b1 || resOut !== e.res || errOut !== e.err) begin nFail++; $display("[TB] FAIL err_clear_result: got valid=%b res=%h err=%b, expected valid=1 res=%h err=%b", resValid, resOut, errOut, e.res, e.err); end
        stepCycle();
    endtask

    task automatic test_alu_stall();
        int   edges;
        exp_t e;
        aluDone = 1'b0;
        sbQ.push_back('{16'd10, 16'd0, 1'b0});
        applyStimulus(8'd5, 8'd5, 2'b00);
        for (int i = 0; i < 6; i++) begin
            stepCycle();
            nTests++; if (resValid !== 1'b0 || busy !== 1'b1) begin nFail++; $display("[TB] FAIL stall%0d_wait: got valid=%b busy=%b, expected valid=0 busy=1", i, resValid, busy); end
        end
        aluDone = 1'b1;
        collectResult(edges);
        nTests++; if (resValid !== 1'b1 || edges != 1) begin nFail++; $display("[TB] FAIL stall_release: got %0d edges valid=%b, expected 1 edge", edges, resValid); end
        e = sbQ.pop_front();
        expCount = (expCount + 1) % 256;
        nTests++; if (resOut !== e.res) begin nFail++; $display("[TB] FAIL stall_res: got %h, expected %h", resOut, e.res); end
        nTests++; if (opCount !== 8'(expCount)) begin nFail++; $display("[TB] FAIL stall_op_count: got %0d, expected %0d", opCount, expCount); end
        stepCycle();
    endtask

    task automatic test_back_to_back();
        int   edges;
        exp_t e;
        resReady = 1'b0;
        sbQ.push_back('{16'd30, 16'd0, 1'b0});
        applyStimulus(8'd10, 8'd20, 2'b00);
        collectResult(edges);
        e = sbQ.pop_front();
        expCount = (expCount + 1) % 256;
        nTests++; if (resValid !== 1'b1 || resOut !== e.res) begin nFail++; $display("[TB] FAIL b2b_first_res: got valid=%b res=%h, expected valid=1 res=%h", resValid, resOut, e.res); end
        // Pending request with new operands while the consumer stalls.
        reqValid = 1'b1;
        aIn      = 8'd50;
        bIn      = 8'd60;
        fctIn    = 2'b00;
        for (int i = 0; i < 5; i++) begin
            stepCycle();
            nTests++; if (resValid !== 1'b1 || resOut !== 16'd30) begin nFail++; $display("[TB] FAIL b2b_hold%0d_res: got valid=%b res=%h, expected valid=1 res=001e", i, resValid, resOut); end
            nTests++; if (reqReady !== 1'b0) begin nFail++; $display("[TB] FAIL b2b_hold%0d_ready: got %b, expected 0", i, reqReady); end
            nTests++; if (aluA !== 8'd10 || aluB !== 8'd20) begin nFail++; $display("[TB] FAIL b2b_hold%0d_operands: got %h/%h, expected 0a/14", i, aluA, aluB); end
        end
        sbQ.push_back('{16'd110, 16'd0, 1'b0});
        resReady = 1'b1;
        stepCycle();
        nTests++; if (resValid !== 1'b0 || reqReady !== 1'b1 || aluA !== 8'd10) begin nFail++; $display("[TB] FAIL b2b_handoff: got valid=%b ready=%b aluA=%h, expected valid=0 ready=1 aluA=0a", resValid, reqReady, aluA); end
        stepCycle();
        reqValid = 1'b0;
        nTests++; if (busy !== 1'b1 || aluA !== 8'd50 || aluB !== 8'd60) begin nFail++; $display("[TB] FAIL b2b_pending_accept: got busy=%b ops=%h/%h, expected busy=1 ops=32/3c", busy, aluA, aluB); end
        collectResult(edges);
        e = sbQ.pop_front();
        expCount = (expCount + 1) % 256;
        nTests++; if (resValid !== 1'b1 || edges != EXEC_CYCLES || resOut !== e.res) begin nFail++; $display("[TB] FAIL b2b_second_res: got valid=%b edges=%0d res=%h, expected valid=1 edges=%0d res=%h", resValid, edges, resOut, EXEC_CYCLES, e.res); end
        nTests++; if (opCount !== 8'(expCount)) begin nFail++; $display("[TB] FAIL b2b_op_count: got %0d, expected %0d", opCount, expCount); end
        stepCycle();
    endtask

    task automatic test_reset_mid();
        int   edges;
        exp_t e;
        // This operation is aborted by reset, so nothing is queued for it.
        applyStimulus(8'd7, 8'd6, 2'b10);
        stepCycle();
        rst = 1'b1;
        #1;
        expCount = 0;
        nTests++; if (resValid !== 1'b0 || busy !== 1'b0) begin nFail++; $display("[TB] FAIL rstmid_flags: got valid=%b busy=%b, expected 0/0", resValid, busy); end
        nTests++; if (reqReady !== 1'b1) begin nFail++; $display("[TB] FAIL rstmid_ready: got %b, expected 1", reqReady); end
        nTests++; if (opCount !== 8'd0) begin nFail++; $display("[TB] FAIL rstmid_op_count: got %0d, expected 0", opCount); end
        stepCycle();
        rst = 1'b0;
        stepCycle();
        nTests++; if (opCount !== 8'd0 || resValid !== 1'b0) begin nFail++; $display("[TB] FAIL rstmid_no_capture: got count=%0d valid=%b, expected 0/0", opCount, resValid); end
        sbQ.push_back('{16'd10, 16'd0, 1'b0});
        applyStimulus(8'd12, 8'd2, 2'b01);
        collectResult(edges);
        e = sbQ.pop_front();
        expCount = (expCount + 1) % 256;
        nTests++; if (resValid !== 1'b1 || edges != EXEC_CYCLES || resOut !== e.res) begin nFail++; $display("[TB] FAIL rstmid_next_res: got valid=%b edges=%0d res=%h, expected valid=1 edges=%0d res=%h", resValid, edges, resOut, EXEC_CYCLES, e.res); end
        nTests++; if (opCount !== 8'(expCount)) begin nFail++; $display("[TB] FAIL rstmid_next_op_count: got %0d, expected %0d", opCount, expCount); end
        stepCycle();
    endtask

    // Run every scenario in order and print the summary.
    initial begin
        test_reset();
        test_arith();
        test_err_clear();
        test_alu_stall();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

    // Global bound so a stuck design cannot hang the run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/calc_ctrl.md
Name: calc_ctrl

Overview:
- Sequencing controller for the calculator's combinational ALU.
- Accepts one operation request (a, b, fct) through a valid/ready handshake and holds the operands stable on the ALU inputs for a fixed multicycle window.
- Captures the ALU result/remainder and presents it through a second valid/ready handshake.
- Sits between the key-entry/decode logic and the ALU; the ALU is instantiated beside it, not inside it.

Parameters:
- WIDTH, 8, operand width; result and remainder are 2*WIDTH.
- EXEC_CYCLES, 2, minimum cycles the operands are held on the ALU before capture; legal range 1..16.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous reset, active high.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  controller can accept a request.
- a_i  in  WIDTH  operand A.
- b_i  in  WIDTH  operand B.
- fct_i  in  2  op code: 00 add, 01 sub, 10 mul, 11 div.
- alu_a_o  out  WIDTH  to ALU operand A.
- alu_b_o  out  WIDTH  to ALU operand B.
- alu_fct_o  out  2  to ALU op code.
- alu_res_i  in  2*WIDTH  from ALU result.
- alu_rem_i  in  2*WIDTH  from ALU remainder.
- alu_done_i  in  1  from ALU done.
- res_valid_o  out  1  result valid.
- res_ready_i  in  1  consumer accepts result.
- res_o  out  2*WIDTH  registered result.
- rem_o  out  2*WIDTH  registered remainder.
- err_o  out  1  divide-by-zero flag for the presented result.
- busy_o  out  1  high in EXEC or RESP.
- op_count_o  out  8  completed-operation counter.

Behaviour:
- Clock and reset: single clock clk_i; reset rst_i is asynchronous and active high.
- Reset values:
  - State = IDLE.
  - Operand registers, res_o, rem_o, err_o, op_count_o all 0.
  - res_valid_o = 0, busy_o = 0.
  - req_ready_o = 1, since it decodes IDLE.
- States: IDLE, EXEC, RESP.
- IDLE:
  - req_ready_o = 1.
  - On req_valid_i & req_ready_o at an edge: latch a_i, b_i and fct_i into registers, load cnt = EXEC_CYCLES-1, go to EXEC.
  - On the same edge, clear err_o.
- EXEC:
  - alu_a_o, alu_b_o and alu_fct_o are driven only from the latched registers, so they stay stable for the whole state.
  - Outside EXEC they hold their last values.
  - cnt decrements each edge while nonzero.
  - When cnt == 0 and alu_done_i == 1: capture alu_res_i into res_o and alu_rem_i into rem_o, increment op_count_o (wraps 255 -> 0), go to RESP.
  - When cnt == 0 and alu_done_i == 0: remain in EXEC with no timeout.
- RESP:
  - res_valid_o = 1.
  - res_o, rem_o and err_o are held stable until res_valid_o & res_ready_i, then go to IDLE.
- Latency: res_valid_o rises EXEC_CYCLES edges after the accept edge, given alu_done_i = 1.
- Throughput: one operation per EXEC_CYCLES+2 cycles at best.
- Request handling:
  - req_ready_o = 0 in EXEC and RESP.
  - req_valid_i is ignored there; the controller does not latch it.
  - No accept in the same cycle as a result handoff; the controller returns to IDLE first.
- Arithmetic: the controller does no arithmetic; ALU outputs pass through unmodified. Subtraction underflow wraps in 2*WIDTH bits, for example 3-5 = 16'hFFFE.
- Reset mid-operation: asynchronous return to IDLE with reset values; the in-flight operation is discarded and op_count_o is not incremented.

Optional Feature:
- Macro: CALC_DIVZERO_ERR_EN.
- Defined: at the capture edge, err_o <= (fct_reg == 2'b11 && b_reg == 0); res_o and rem_o are captured as returned by the ALU (0/0).
- Not defined: err_o is constant 0 and no compare logic is generated. Port list is unchanged.

Decomposition:
- Package calc_pkg:
  - fct_e enum: ADD=2'b00, SUB=2'b01, MUL=2'b10, DIV=2'b11.
  - ctrl_state_e enum: IDLE, EXEC, RESP.
  - Constant OP_CNT_W = 8.
- The ALU also imports fct_e.
- No sub-module: the counter and FSM live in calc_ctrl.
- The top level instantiates calc_ctrl and the ALU side by side.

Test Plan (WIDTH=8, EXEC_CYCLES=2, ALU connected):
- a=25, b=17, fct=00, res_ready_i=1 -> res_valid_o high exactly 2 edges after accept; res_o=42, rem_o=0; op_count_o=1.
- a=3, b=5, fct=01 -> res_o=16'hFFFE. Then a=200, b=200, fct=10 -> res_o=16'h9C40.
- a=100, b=7, fct=11 -> res_o=14, rem_o=2, err_o=0.
- a=9, b=0, fct=11 -> res_o=0, rem_o=0; err_o=1 with CALC_DIVZERO_ERR_EN, err_o=0 without; err_o clears on the next accept.
- res_ready_i held low 5 cycles with req_valid_i=1 and new operands -> res_o stable, req_ready_o=0, new operands not latched. After the handoff, IDLE accepts the pending request on the next edge.
- rst_i pulsed mid-EXEC -> res_valid_o=0, busy_o=0, op_count_o unchanged at 0, req_ready_o=1. The next operation completes correctly.
